// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// Two-master arbiter for the shared data-memory/MMIO port: M0 = core load/store, M1 = UART loader.
// Round-robin by default; define MEM_BUS_FIXED_PRIO_EN for fixed priority (M0 always wins a tie).
module mem_bus_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [1:0]        m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_rmode,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [1:0]        m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_rmode,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_rmode,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              cpu_stall
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;
  logic                r_last_owner;
  logic [3:0]          r_cnt;
  logic [1:0]          r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_rmode;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_grant;
  logic                w_win;
  logic                w_access;
  logic                w_resp;
  logic                w_done;
  logic [DATA_W-1:0]   w_capture;

  assign w_access  = (r_state == ST_ACCESS);
  assign w_resp    = (r_state == ST_RESP);
  assign w_done    = w_access && (r_cnt == 4'd0);
  assign w_capture = (r_we == 2'b00) ? mem_rdata : '0;

  // Winner selection: 0 = M0, 1 = M1.
  always_comb begin
    w_win = 1'b0;
`ifdef MEM_BUS_FIXED_PRIO_EN
    w_win = ~m0_req;
`else
    if (m0_req && m1_req) begin
      w_win = ~r_last_owner;
    end else begin
      w_win = ~m0_req;
    end
`endif
  end

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          w_grant = 1'b1;
          w_next  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Command is captured once at grant so requester-side changes mid-access are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_cnt        <= 4'd0;
      r_we         <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rmode      <= 3'b000;
    end else begin
      if (w_grant) begin
        r_owner <= w_win;
        r_cnt   <= 4'(WAIT_CYCLES);
        if (w_win) begin
          r_we    <= m1_we;
          r_addr  <= m1_addr;
          r_wdata <= m1_wdata;
          r_rmode <= m1_rmode;
        end else begin
          r_we    <= m0_we;
          r_addr  <= m0_addr;
          r_wdata <= m0_wdata;
          r_rmode <= m0_rmode;
        end
      end else if (w_access && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_resp) begin
        r_last_owner <= r_owner;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else if (w_done) begin
      if (r_owner) begin
        r_m1_rdata <= w_capture;
      end else begin
        r_m0_rdata <= w_capture;
      end
    end
  end

  // Memory-side outputs are forced to zero outside ACCESS so reset drops them asynchronously.
  assign mem_en    = w_access;
  assign mem_we    = w_access ? r_we    : 2'b00;
  assign mem_addr  = w_access ? r_addr  : '0;
  assign mem_wdata = w_access ? r_wdata : '0;
  assign mem_rmode = w_access ? r_rmode : 3'b000;

  assign gnt       = (w_access || w_resp) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = w_access || w_resp;
  assign m0_ack    = w_resp && !r_owner;
  assign m1_ack    = w_resp &&  r_owner;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;
  assign cpu_stall = m0_req & ~m0_ack;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single data-memory/MMIO port between two requesters: M0 (the core's load/store path, driven by the controller's MemWrite/READMODE decode) and M1 (the UART program loader). Round-robin arbitration with a fixed-latency memory access sequencer and a one-cycle ack pulse per transaction. Sits between the core/UART loader and data memory. Its stall output freezes the core PC while a core access is outstanding.

Parameters:
WAIT_CYCLES, 1, extra memory latency cycles per access; legal range 0..15.
ADDR_W, 32, address width.
DATA_W, 32, data width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
m0_req  in  1  core request, level
m0_we  in  2  00 read, 01 byte, 10 half, 11 word store (MemWrite encoding)
m0_addr  in  ADDR_W  core address
m0_wdata  in  DATA_W  core store data
m0_rmode  in  3  load mode (READMODE encoding)
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DATA_W  read data, valid with m0_ack, held until the next m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_rmode  in  (same widths)  UART loader request
m1_ack  out  1  completion pulse
m1_rdata  out  DATA_W  read data
mem_en  out  1  memory access strobe
mem_we  out  2  store size to memory, 00 = read
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_rmode  out  3  latched load mode
mem_rdata  in  DATA_W  memory read data
gnt  out  2  one-hot current owner; 00 when IDLE
busy  out  1  high in ACCESS or RESP
cpu_stall  out  1  combinational: m0_req & ~m0_ack

Behaviour:
- Reset (async, reset=0): state IDLE; all outputs 0 (the combinational cpu_stall follows m0_req); last_owner=1, so M0 wins the first tie; counter 0; both rdata registers 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that master.
- IDLE, both requesting: grant the master that is not last_owner.
- On grant: latch the winner's we/addr/wdata/rmode into command registers; cnt <= WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_* driven from the latched command; gnt = owner one-hot.
  - While cnt != 0, decrement cnt.
  - At cnt == 0: capture mem_rdata into the owner's rdata register (reads only; writes load 0) and go to RESP.
  - ACCESS lasts exactly WAIT_CYCLES+1 cycles.
- RESP: mem_en=0, mem_we=00; owner's ack=1 for exactly one cycle; last_owner <= owner; go to IDLE.
- Latency: request first sampled in IDLE at cycle T → mem_en high cycles T+1..T+1+WAIT_CYCLES → ack at T+WAIT_CYCLES+2.
- Minimum spacing: a master's next grant comes no earlier than the cycle after its ack (IDLE always lasts at least one cycle). Throughput is one access per WAIT_CYCLES+3 cycles.
- Requester rules:
  - Keep req and the command stable until ack.
  - Dropping req is permitted once ack is seen.
  - A req still high in the ack cycle is treated as a new request.
  - req dropped mid-transaction: the transaction still completes and ack still pulses. The command was latched at grant, so later input changes have no effect.
- mem_we is nonzero only in ACCESS; mem_en is never high in IDLE or RESP.
- Invalid rmode/we codes pass through unmodified; the memory decides.
- Reset asserted mid-ACCESS: mem_en and mem_we drop immediately (async), no ack is issued, and last_owner returns to 1.
- WAIT_CYCLES=0: ACCESS is a single cycle.

Optional Feature:
Macro MEM_BUS_FIXED_PRIO_EN.
- Defined: fixed priority, M0 always wins when both request; last_owner is unused; M1 can starve.
- Undefined (default): round-robin as above.

Test Plan:
- WAIT_CYCLES=1; m0 read addr 0x100, memory returns 0xDEADBEEF → mem_en high 2 cycles, m0_ack at T+3, m0_rdata=0xDEADBEEF; cpu_stall high T..T+2, low at T+3.
- m0 and m1 both held high for 4 transactions → grants alternate M0,M1,M0,M1; each ack spaced WAIT_CYCLES+3 cycles.
- m1 store word (we=11) addr 0x40 data 0x12345678 → mem_we=11 and mem_wdata=0x12345678 only during ACCESS; m1_rdata=0; m1_ack single pulse.
- m0 store byte (we=01), inputs changed mid-ACCESS → mem_addr/mem_wdata keep the latched values; m0_ack still pulses.
- reset driven low during ACCESS → mem_en=0 and gnt=00 immediately with no ack; after release, simultaneous req grants M0 first.
- MEM_BUS_FIXED_PRIO_EN defined, both requesting continuously → M0 granted every transaction; m1_ack never asserted.
